// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, arbiter state and Avalon write-request type for the SDRAM write path
package sdram_pkg;
  localparam int ADDRESS_BITS = 29;
  localparam int DATA_BITS    = 64;
  localparam int BURST_BITS   = 8;
  typedef enum logic {IDLE, BURST} arb_state_t;
  typedef struct packed {
    logic [ADDRESS_BITS-1:0]  address;
    logic [BURST_BITS-1:0]    burstcount;
    logic [DATA_BITS-1:0]     writedata;
    logic [DATA_BITS/8-1:0]   byteenable;
    logic                     write;
  } avl_wr_req_t;
endpackage

// File: rtl/round_robin_pick.sv
// round_robin_pick: two-way picker; on a tie the master that did not win last time wins
module round_robin_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last_grant : req1;
  end
endmodule

// File: rtl/sdram_write_arbiter.sv
// sdram_write_arbiter: burst-locked round-robin share of one f2h SDRAM write port between color (m0) and Z (m1).
// Define SDRAM_ARB_STATS_EN to build the burst/contention counters behind debug_value0..2.
module sdram_write_arbiter #(
  parameter int ADDRESS_BITS = sdram_pkg::ADDRESS_BITS,
  parameter int DATA_BITS    = sdram_pkg::DATA_BITS,
  parameter int BURST_BITS   = sdram_pkg::BURST_BITS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDRESS_BITS-1:0] m0_address,
  input  logic [BURST_BITS-1:0]   m0_burstcount,
  input  logic [DATA_BITS-1:0]    m0_writedata,
  input  logic [DATA_BITS/8-1:0]  m0_byteenable,
  input  logic                    m0_write,
  output logic                    m0_waitrequest,
  input  logic [ADDRESS_BITS-1:0] m1_address,
  input  logic [BURST_BITS-1:0]   m1_burstcount,
  input  logic [DATA_BITS-1:0]    m1_writedata,
  input  logic [DATA_BITS/8-1:0]  m1_byteenable,
  input  logic                    m1_write,
  output logic                    m1_waitrequest,
  output logic [ADDRESS_BITS-1:0] s_address,
  output logic [BURST_BITS-1:0]   s_burstcount,
  output logic [DATA_BITS-1:0]    s_writedata,
  output logic [DATA_BITS/8-1:0]  s_byteenable,
  output logic                    s_write,
  input  logic                    s_waitrequest,
  output logic [31:0]             debug_value0,
  output logic [31:0]             debug_value1,
  output logic [31:0]             debug_value2
);
  import sdram_pkg::*;
  arb_state_t            state;
  logic                  grant, last_grant, first_beat;
  logic [BURST_BITS-1:0] beats_left;
  logic                  pick_valid, pick_winner, burst, accept, last_beat;
  round_robin_pick u_pick (
    .req0       (m0_write),
    .req1       (m1_write),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );
  always_comb begin
    burst          = state == BURST;
    s_address      = grant ? m1_address    : m0_address;
    s_burstcount   = grant ? m1_burstcount : m0_burstcount;
    s_writedata    = grant ? m1_writedata  : m0_writedata;
    s_byteenable   = grant ? m1_byteenable : m0_byteenable;
    s_write        = burst && (grant ? m1_write : m0_write);
    m0_waitrequest = (burst && !grant) ? s_waitrequest : 1'b1;
    m1_waitrequest = (burst && grant)  ? s_waitrequest : 1'b1;
    accept         = s_write && !s_waitrequest;
    // burstcount 0 behaves as a single beat, hence <= 1 on both paths
    last_beat      = first_beat ? (s_burstcount <= BURST_BITS'(1)) : (beats_left <= BURST_BITS'(1));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      first_beat <= 1'b0;
      beats_left <= '0;
    end else if (!burst) begin
      if (pick_valid) begin
        grant      <= pick_winner;
        first_beat <= 1'b1;
        state      <= BURST;
      end
    end else if (accept) begin
      first_beat <= 1'b0;
      beats_left <= first_beat ? ((s_burstcount == '0) ? '0 : s_burstcount - BURST_BITS'(1)) : beats_left - BURST_BITS'(1);
      if (last_beat) begin
        last_grant <= grant;
        state      <= IDLE;
      end
    end
  end
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] bursts0, bursts1, stalls;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bursts0 <= '0;
      bursts1 <= '0;
      stalls  <= '0;
    end else begin
      if (accept && last_beat && !grant) bursts0 <= bursts0 + 32'd1;
      if (accept && last_beat && grant) bursts1 <= bursts1 + 32'd1;
      if (burst && (grant ? m0_write : m1_write)) stalls <= stalls + 32'd1;
    end
  end
  assign debug_value0 = bursts0;
  assign debug_value1 = bursts1;
  assign debug_value2 = stalls;
`else
  assign debug_value0 = '0;
  assign debug_value1 = '0;
  assign debug_value2 = '0;
`endif
endmodule

// File: tb/tb_sdram_write_arbiter.sv
// tb_sdram_write_arbiter: directed vectors with hand-computed expectations for sdram_write_arbiter
module tb_sdram_write_arbiter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [28:0] m0_address = '0, m1_address = '0, s_address;
  logic [7:0]  m0_burstcount = '0, m1_burstcount = '0, s_burstcount;
  logic [63:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
  logic [7:0]  m0_byteenable = 8'hff, m1_byteenable = 8'hff, s_byteenable;
  logic        m0_write = 1'b0, m1_write = 1'b0, s_write;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest = 1'b0;
  logic [31:0] debug_value0, debug_value1, debug_value2;
  int          n_checks = 0, n_fail = 0;
  always #5 clock = ~clock;
  sdram_write_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .debug_value0(debug_value0), .debug_value1(debug_value1), .debug_value2(debug_value2)
  );
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    m0_write = 1'b0;
    m1_write = 1'b0;
    s_waitrequest = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    logic pat [12] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int   acc, cyc, k;
    logic done;
    @(negedge clock); #1;
    check_eq("rst_s_write", 64'(s_write), 64'd0);
    check_eq("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
    check_eq("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
    check_eq("rst_dbg0", 64'(debug_value0), 64'd0);
    check_eq("rst_dbg1", 64'(debug_value1), 64'd0);
    check_eq("rst_dbg2", 64'(debug_value2), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    // master 0 alone, burst of 4
    @(negedge clock); m0_write = 1'b1; m0_burstcount = 8'd4; m0_address = 29'h100; #1;
    check_eq("t1_idle_s_write", 64'(s_write), 64'd0);
    check_eq("t1_idle_m0_wait", 64'(m0_waitrequest), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); m0_writedata = 64'hA0 + 64'(i); #1;
      check_eq("t1_s_write", 64'(s_write), 64'd1);
      check_eq("t1_s_address", 64'(s_address), 64'h100);
      check_eq("t1_s_writedata", s_writedata, 64'hA0 + 64'(i));
      check_eq("t1_m0_wait", 64'(m0_waitrequest), 64'd0);
      check_eq("t1_m1_wait", 64'(m1_waitrequest), 64'd1);
    end
    @(negedge clock); m0_write = 1'b0; #1;
    check_eq("t1_end_m0_wait", 64'(m0_waitrequest), 64'd1);
    check_eq("t1_end_m1_wait", 64'(m1_waitrequest), 64'd1);
    // tie after reset: master 0 burst, dead cycle, master 1 burst
    do_reset;
    @(negedge clock);
    m0_write = 1'b1; m1_write = 1'b1; m0_burstcount = 8'd2; m1_burstcount = 8'd2;
    m0_address = 29'h200; m1_address = 29'h300; #1;
    check_eq("t2_idle_s_write", 64'(s_write), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      check_eq("t2_b0_s_write", 64'(s_write), 64'd1);
      check_eq("t2_b0_s_address", 64'(s_address), 64'h200);
      check_eq("t2_b0_m1_wait", 64'(m1_waitrequest), 64'd1);
    end
    @(negedge clock); m0_write = 1'b0; #1;
    check_eq("t2_dead_s_write", 64'(s_write), 64'd0);
    check_eq("t2_dead_m1_wait", 64'(m1_waitrequest), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      check_eq("t2_b1_s_address", 64'(s_address), 64'h300);
      check_eq("t2_b1_m0_wait", 64'(m0_waitrequest), 64'd1);
      check_eq("t2_b1_m1_wait", 64'(m1_waitrequest), 64'd0);
    end
    @(negedge clock); m1_write = 1'b0; #1;
    check_eq("t2_end_s_write", 64'(s_write), 64'd0);
    // master 1 burst of 8, two 2-cycle stalls: 8 beats + 4 stall cycles
    @(negedge clock); m1_write = 1'b1; m1_burstcount = 8'd8; #1;
    check_eq("t3_idle_s_write", 64'(s_write), 64'd0);
    acc = 0; cyc = 0; k = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clock); s_waitrequest = (k < 12) ? pat[k] : 1'b0; #1;
      if (!s_write) begin
        done = 1'b1;
        m1_write = 1'b0;
        s_waitrequest = 1'b0;
      end else begin
        cyc++;
        if (!s_waitrequest) acc++;
        check_eq("t3_m1_wait_mirror", 64'(m1_waitrequest), 64'(s_waitrequest));
      end
      k++;
    end
    check_eq("t3_done", 64'(done), 64'd1);
    check_eq("t3_beats", 64'(acc), 64'd8);
    check_eq("t3_burst_cycles", 64'(cyc), 64'd12);
    // burstcount 0 acts as a single beat
    @(negedge clock); m0_write = 1'b1; m0_burstcount = 8'd0; #1;
    check_eq("t4_idle_s_write", 64'(s_write), 64'd0);
    @(negedge clock); #1;
    check_eq("t4_beat_s_write", 64'(s_write), 64'd1);
    check_eq("t4_beat_m0_wait", 64'(m0_waitrequest), 64'd0);
    @(negedge clock); m0_write = 1'b0; #1;
    check_eq("t4_back_idle", 64'(m0_waitrequest), 64'd1);
    // reset after beat 2 of 4, then a tie goes to master 0
    @(negedge clock); m0_write = 1'b1; m0_burstcount = 8'd4; m0_address = 29'h100; #1;
    check_eq("t5_idle_s_write", 64'(s_write), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      check_eq("t5_beat_s_write", 64'(s_write), 64'd1);
    end
    @(negedge clock); reset_n = 1'b0; #1;
    check_eq("t5_rst_s_write", 64'(s_write), 64'd0);
    check_eq("t5_rst_m0_wait", 64'(m0_waitrequest), 64'd1);
    check_eq("t5_rst_m1_wait", 64'(m1_waitrequest), 64'd1);
    @(negedge clock); reset_n = 1'b1; m0_burstcount = 8'd1; m1_write = 1'b1; m1_burstcount = 8'd1; #1;
    check_eq("t5_rel_s_write", 64'(s_write), 64'd0);
    @(negedge clock); #1;
    check_eq("t5_tie_m0_wait", 64'(m0_waitrequest), 64'd0);
    check_eq("t5_tie_m1_wait", 64'(m1_waitrequest), 64'd1);
    check_eq("t5_tie_s_address", 64'(s_address), 64'h100);
    // continuous 1-beat contention: grants alternate 0,1,0,1,0
    do_reset;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0) begin
        m0_write = 1'b1; m1_write = 1'b1; m0_burstcount = 8'd1; m1_burstcount = 8'd1;
      end
      #1;
      if (c % 2 == 0) check_eq("t6_idle_s_write", 64'(s_write), 64'd0);
      else begin
        check_eq("t6_s_write", 64'(s_write), 64'd1);
        check_eq("t6_grant", 64'(m0_waitrequest), 64'((c / 2) % 2));
      end
    end
    @(negedge clock); m0_write = 1'b0; m1_write = 1'b0;
    @(negedge clock); #1;
`ifdef SDRAM_ARB_STATS_EN
    check_eq("stats_dbg0", 64'(debug_value0), 64'd3);
    check_eq("stats_dbg1", 64'(debug_value1), 64'd2);
    check_eq("stats_dbg2_nonzero", 64'(debug_value2 != 32'd0), 64'd1);
`else
    check_eq("stats_dbg0", 64'(debug_value0), 64'd0);
    check_eq("stats_dbg1", 64'(debug_value1), 64'd0);
    check_eq("stats_dbg2", 64'(debug_value2), 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
